reg_file_wb_arbiter: RTL and testbench

REG_FILE_WB_ARBITER -- requirements
Module: reg_file_wb_arbiter

---
 rtl/reg_file_wb_arbiter.sv | 139 +++++++++++++
 tb/tb_reg_file_wb_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_wb_arbiter.sv
// Writeback arbiter: two requester FIFOs share one register-file write port.
// Round-robin grant, registered WB_* outputs, pending-write hazard query.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_FILE_DEPTH
`define REG_FILE_DEPTH 4
`endif

module reg_file_wb_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_valid,
    input  logic [`REG_FILE_DEPTH-1:0] a_dest,
    input  logic [`WORD_WIDTH-1:0]     a_res,
    output logic                       a_ready,
    input  logic                       b_valid,
    input  logic [`REG_FILE_DEPTH-1:0] b_dest,
    input  logic [`WORD_WIDTH-1:0]     b_res,
    output logic                       b_ready,
    input  logic [`REG_FILE_DEPTH-1:0] src1,
    input  logic [`REG_FILE_DEPTH-1:0] src2,
    output logic                       hit1,
    output logic                       hit2,
    output logic                       WB_EN,
    output logic [`REG_FILE_DEPTH-1:0] WB_Dest,
    output logic [`WORD_WIDTH-1:0]     WB_Res,
    output logic                       busy
);
    localparam int PW = (FIFO_DEPTH == 4) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

    // Index 0 is requester A, index 1 is requester B.
    logic [`REG_FILE_DEPTH-1:0] q_dest [2][FIFO_DEPTH];
    logic [`WORD_WIDTH-1:0]     q_res  [2][FIFO_DEPTH];
    logic [PW-1:0]              wp     [2];
    logic [PW-1:0]              rp     [2];
    logic [CW-1:0]              cnt    [2];
    logic                       last_b;

    logic [`REG_FILE_DEPTH-1:0] in_dest [2];
    logic [`WORD_WIDTH-1:0]     in_res  [2];
    logic [1:0]                 in_valid;
    logic [1:0]                 ready;
    logic [1:0]                 nonempty;
    logic [1:0]                 push;
    logic [1:0]                 pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    function automatic logic occupied(input logic [PW-1:0] idx,
                                      input logic [PW-1:0] head,
                                      input logic [CW-1:0] n);
        logic [PW-1:0] off;
        off = idx - head;
        return {1'b0, off} < n;
    endfunction

    always_comb begin
        in_valid   = {b_valid, a_valid};
        in_dest[0] = a_dest;
        in_dest[1] = b_dest;
        in_res[0]  = a_res;
        in_res[1]  = b_res;
        for (int r = 0; r < 2; r++) begin
            ready[r]    = (cnt[r] != FULL);
            nonempty[r] = (cnt[r] != '0);
            push[r]     = in_valid[r] & ready[r];
        end
        // A wins unless B is waiting and A was served last.
        pop[0] = nonempty[0] & (~nonempty[1] | last_b);
        pop[1] = nonempty[1] & ~pop[0];
    end

    assign a_ready = ready[0];
    assign b_ready = ready[1];
    assign busy    = nonempty[0] | nonempty[1] | WB_EN;

    always_comb begin
        hit1 = WB_EN && (WB_Dest == src1);
        hit2 = WB_EN && (WB_Dest == src2);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (occupied(PW'(i), rp[r], cnt[r])) begin
                    if (q_dest[r][i] == src1) hit1 = 1'b1;
                    if (q_dest[r][i] == src2) hit2 = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 2; r++) begin
                wp[r]  <= '0;
                rp[r]  <= '0;
                cnt[r] <= '0;
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    q_dest[r][i] <= '0;
                    q_res[r][i]  <= '0;
                end
            end
            last_b  <= 1'b1;
            WB_EN   <= 1'b0;
            WB_Dest <= '0;
            WB_Res  <= '0;
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (push[r]) begin
                    q_dest[r][wp[r]] <= in_dest[r];
                    q_res[r][wp[r]]  <= in_res[r];
                    wp[r]            <= nxt(wp[r]);
                end
                if (pop[r]) rp[r] <= nxt(rp[r]);
                cnt[r] <= cnt[r] + CW'(push[r]) - CW'(pop[r]);
            end
            if (pop[0]) begin
                WB_EN   <= 1'b1;
                WB_Dest <= q_dest[0][rp[0]];
                WB_Res  <= q_res[0][rp[0]];
                last_b  <= 1'b0;
            end else if (pop[1]) begin
                WB_EN   <= 1'b1;
                WB_Dest <= q_dest[1][rp[1]];
                WB_Res  <= q_res[1][rp[1]];
                last_b  <= 1'b1;
            end else begin
                WB_EN <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Directed-vector bench for reg_file_wb_arbiter (FIFO_DEPTH = 2).
// Inputs change 1 ns after posedge; outputs are sampled there too.
module tb_reg_file_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [3:0]  a_dest, b_dest, src1, src2, WB_Dest;
    logic [31:0] a_res, b_res, WB_Res;
    logic        hit1, hit2, WB_EN, busy;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [31:0] RA = 32'hAAAA_0000;
    localparam logic [31:0] RB = 32'hBBBB_0000;

    reg_file_wb_arbiter #(.FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_dest(a_dest), .a_res(a_res), .a_ready(a_ready),
        .b_valid(b_valid), .b_dest(b_dest), .b_res(b_res), .b_ready(b_ready),
        .src1(src1), .src2(src2), .hit1(hit1), .hit2(hit2),
        .WB_EN(WB_EN), .WB_Dest(WB_Dest), .WB_Res(WB_Res), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 1'b0; b_valid = 1'b0;
        a_dest = '0; b_dest = '0; a_res = '0; b_res = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        idle();
        src1 = 4'd0; src2 = 4'd0;
        rst = 1'b1;
        #3;
        check("rst_wb_en",   32'(WB_EN),   0);
        check("rst_wb_dest", 32'(WB_Dest), 0);
        check("rst_wb_res",  WB_Res,       0);
        check("rst_a_ready", 32'(a_ready), 1);
        check("rst_b_ready", 32'(b_ready), 1);
        check("rst_hit1",    32'(hit1),    0);
        check("rst_hit2",    32'(hit2),    0);
        check("rst_busy",    32'(busy),    0);
        rst = 1'b0;
        tick();

        // single write with no bypass
        a_valid = 1'b1; a_dest = 4'd3; a_res = 32'hDEAD_BEEF; src1 = 4'd3;
        #1;
        check("sw_hit_prepush", 32'(hit1), 0);
        tick();
        idle();
        check("sw_no_bypass", 32'(WB_EN), 0);
        check("sw_busy_q",    32'(busy),  1);
        check("sw_hit_queued", 32'(hit1), 1);
        tick();
        check("sw_wb_en",   32'(WB_EN),   1);
        check("sw_wb_dest", 32'(WB_Dest), 3);
        check("sw_wb_res",  WB_Res,       32'hDEAD_BEEF);
        tick();
        check("sw_done_en",   32'(WB_EN),   0);
        check("sw_done_busy", 32'(busy),    0);
        check("sw_dest_hold", 32'(WB_Dest), 3);

        // contention right after reset: A first
        do_reset();
        a_valid = 1'b1; a_dest = 4'd1; a_res = 32'h11;
        b_valid = 1'b1; b_dest = 4'd2; b_res = 32'h22;
        tick();
        idle();
        tick();
        check("ct_first_dest", 32'(WB_Dest), 1);
        check("ct_first_res",  WB_Res,       32'h11);
        tick();
        check("ct_second_dest", 32'(WB_Dest), 2);
        check("ct_second_res",  WB_Res,       32'h22);
        tick();
        check("ct_idle", 32'(WB_EN), 0);

        // backpressure on B while A stays busy
        do_reset();
        a_valid = 1'b1; a_dest = 4'd9; a_res = 32'hA0;
        b_valid = 1'b1; b_dest = 4'd7; b_res = 32'd1;
        tick();
        check("bp_e1_bready", 32'(b_ready), 1);
        b_res = 32'd2;
        tick();
        check("bp_e2_res",    WB_Res,       32'hA0);
        check("bp_e2_bready", 32'(b_ready), 0);
        b_res = 32'd3;
        tick();
        check("bp_e3_res",    WB_Res,       32'd1);
        check("bp_e3_dest",   32'(WB_Dest), 7);
        check("bp_e3_bready", 32'(b_ready), 1);
        check("bp_e3_aready", 32'(a_ready), 0);
        tick();
        check("bp_e4_res", WB_Res, 32'hA0);
        idle();
        tick();
        check("bp_e5_res", WB_Res, 32'd2);
        tick();
        check("bp_e6_res", WB_Res, 32'hA0);
        tick();
        check("bp_e7_res", WB_Res, 32'd3);
        tick();
        check("bp_e8_en",   32'(WB_EN), 0);
        check("bp_e8_busy", 32'(busy),  0);

        // hazard query across queue and writeback stage
        do_reset();
        b_valid = 1'b1; b_dest = 4'd5; b_res = 32'h55;
        src1 = 4'd5; src2 = 4'd6;
        #1;
        check("hz_prepush_hit1", 32'(hit1), 0);
        tick();
        idle();
        check("hz_q_hit1", 32'(hit1), 1);
        check("hz_q_hit2", 32'(hit2), 0);
        tick();
        check("hz_wb_en",   32'(WB_EN),   1);
        check("hz_wb_dest", 32'(WB_Dest), 5);
        check("hz_wb_hit1", 32'(hit1),    1);
        check("hz_wb_hit2", 32'(hit2),    0);
        tick();
        check("hz_done_hit1", 32'(hit1), 0);

        // fairness under continuous contention, then drain
        do_reset();
        a_valid = 1'b1; a_dest = 4'd1; a_res = RA;
        b_valid = 1'b1; b_dest = 4'd2; b_res = RB;
        tick();
        check("fair_e1_en", 32'(WB_EN), 0);
        for (int k = 2; k <= 23; k++) begin
            if (k == 21) idle();
            tick();
            check($sformatf("fair_e%0d", k), WB_Res, (k % 2 == 0) ? RA : RB);
        end
        tick();
        check("fair_drained", 32'(WB_EN), 0);
        check("fair_busy",    32'(busy),  0);

        // asynchronous reset with writes queued and in flight
        a_valid = 1'b1; a_dest = 4'd1; a_res = RA;
        b_valid = 1'b1; b_dest = 4'd2; b_res = RB;
        src1 = 4'd2; src2 = 4'd1;
        tick();
        tick();
        idle();
        check("mr_pre_en",   32'(WB_EN), 1);
        check("mr_pre_hit1", 32'(hit1),  1);
        #1;
        rst = 1'b1;
        #1;
        check("mr_wb_en",   32'(WB_EN),   0);
        check("mr_wb_dest", 32'(WB_Dest), 0);
        check("mr_wb_res",  WB_Res,       0);
        check("mr_aready",  32'(a_ready), 1);
        check("mr_bready",  32'(b_ready), 1);
        check("mr_hit1",    32'(hit1),    0);
        check("mr_hit2",    32'(hit2),    0);
        check("mr_busy",    32'(busy),    0);
        rst = 1'b0;
        tick();
        check("mr_no_stale1", 32'(WB_EN), 0);
        tick();
        check("mr_no_stale2", 32'(WB_EN), 0);
        a_valid = 1'b1; a_dest = 4'd4; a_res = 32'h44;
        b_valid = 1'b1; b_dest = 4'd8; b_res = 32'h88;
        tick();
        idle();
        tick();
        check("mr_a_first", WB_Res, 32'h44);
        tick();
        check("mr_b_next",  WB_Res, 32'h88);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
